change_event_logger: RTL and testbench
======================================

// Module: change_event_logger
// PURPOSE
//   Multi-channel signal-change monitor and event recorder. Samples CHANNELS
//   groups of WIDTH bits each clock. Any masked change pushes an entry into
//   an event FIFO: timestamp, changed-channel mask and full snapshot.
//   Entries drain over a valid/ready interface to a logger or bench checker.
//   Overflow is counted, never silently lost.
// PARAMETERS
//   CHANNELS  3   number of monitored channels
//   WIDTH     1   bits per channel
//   DEPTH     8   FIFO entries; power of 2, >= 2
//   TS_WIDTH  16  free-running timestamp width; wraps
//   DROP_W    8   dropped-event counter width; saturating
// PORTS
//   clk        in   1                clock, rising edge
//   rst        in   1                reset, asynchronous, active-high
//   en         in   1                monitor enable
//   ch_mask    in   CHANNELS         per-channel enable; 1 = watched
//   sig_in     in   CHANNELS*WIDTH   monitored signals; ch i = [i*WIDTH +: WIDTH]
//   out_valid  out  1                FIFO head entry available
//   out_ready  in   1                consumer accepts head entry
//   evt_ts     out  TS_WIDTH         head: timestamp of change
//   evt_mask   out  CHANNELS         head: channels that changed
//   evt_data   out  CHANNELS*WIDTH   head: sig_in snapshot after change
//   level      out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
//   overflow   out  1                sticky: at least one event dropped
//   drop_cnt   out  DROP_W           dropped events, saturating
// BEHAVIOUR
//   Reset (async assert, sync release): FIFO empty, pointers 0, out_valid=0, level=0,
//     ts_cnt=0, overflow=0, drop_cnt=0, armed=0, prev=0. evt_* outputs are 0
//     while empty.
//   Reset mid-operation discards all stored entries immediately. No partial pop.
//   ts_cnt: increments every clk while en=1 and holds while en=0.
//     Wraps 2^TS_WIDTH-1 -> 0.
//   prev register: loads sig_in every edge, regardless of en. armed sets on
//     the first edge after reset.
//   Change detect at edge k: chg[i] = armed & en & ch_mask[i] &
//     (sig_in_i != prev_i). Push when |chg.
//   Pushed entry: {ts_cnt (value before this edge's increment), chg, sig_in}.
//   Latency: the first edge that samples the new value pushes the entry.
//     If the FIFO was empty, out_valid=1 after that same edge.
//   No events while armed=0 or en=0. Re-enabling never reports stale changes,
//     because prev keeps tracking.
//   Several channels changing on one edge produce one entry with a multi-bit
//     evt_mask.
//   Pop on edge when out_valid & out_ready. evt_* always reflect the head
//     entry (FWFT). Order is strictly FIFO.
//   Pop with the FIFO empty: ignored.
//   Full, push, no pop: the entry is dropped and the FIFO is unchanged.
//     drop_cnt += 1, saturating at 2^DROP_W-1. overflow <= 1.
//   Full, push and pop on the same edge: both occur, no drop, level stays
//     DEPTH.
//   level: +1 push only, -1 pop only, unchanged for both or neither.
//   Pointers wrap modulo DEPTH. Full/empty use an extra pointer MSB.
//   overflow and drop_cnt clear only on rst.
// TESTING (CHANNELS=3, WIDTH=1, DEPTH=4, TS_WIDTH=8)
//   1 rst, ch_mask=111, en=1, sig_in=010 held 5 cycles -> out_valid=0,
//     level=0 (no event on arming).
//   2 sig_in 010->011 when ts_cnt=10 -> after that edge: out_valid=1,
//     evt_ts=10, evt_mask=001, evt_data=011.
//   3 ch_mask=110, toggle ch0 -> no entry. Then toggle ch0+ch2 together ->
//     one entry, evt_mask=100.
//   4 out_ready=0, 6 single changes -> level=4, drop_cnt=2, overflow=1.
//     Drain returns the first 4 entries in order with increasing evt_ts.
//   5 full, change + out_ready=1 on the same edge -> no drop, level=4,
//     new entry at tail.
//   6 run past ts 255 -> next event evt_ts=0. Assert rst mid-drain ->
//     out_valid=0 and level=0 without waiting for clk.

Source files
------------

// File: rtl/change_event_logger_if.sv
// Event stream leaving change_event_logger: FWFT head entry under valid/ready.
interface change_event_logger_if #(
  parameter int CHANNELS = 3,
  parameter int WIDTH    = 1,
  parameter int TS_WIDTH = 16
);
  logic                      out_valid;
  logic                      out_ready;
  logic [TS_WIDTH-1:0]       evt_ts;
  logic [CHANNELS-1:0]       evt_mask;
  logic [CHANNELS*WIDTH-1:0] evt_data;

  modport master (output out_valid, evt_ts, evt_mask, evt_data, input out_ready);
  modport slave  (input out_valid, evt_ts, evt_mask, evt_data, output out_ready);
endinterface

// File: rtl/change_event_logger.sv
// Generic FWFT FIFO: head visible combinationally; one cycle from write to read.
// Latency: rd_dat valid the edge after the first write into an empty FIFO.
// Backpressure: a write while full is refused unless a read happens on the same edge.
module event_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [DW-1:0]          wr_dat,
  input  logic                   rd_en,
  output logic [DW-1:0]          rd_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_wr;
  logic          do_rd;

  // Extra MSB separates full from empty when the index bits match.
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd  = rd_en && !empty;
  assign do_wr  = wr_en && (!full || do_rd);
  assign level  = wr_ptr - rd_ptr;
  assign rd_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end
endmodule

// Change monitor: logs {timestamp, changed mask, snapshot} for every masked change.
// Latency: entry pushed on the edge that first samples the new value; out_valid after it.
// Backpressure: out_ready stalls the head; a push into a full FIFO is dropped and counted.
module change_event_logger #(
  parameter int CHANNELS = 3,
  parameter int WIDTH    = 1,
  parameter int DEPTH    = 8,
  parameter int TS_WIDTH = 16,
  parameter int DROP_W   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [CHANNELS-1:0]         ch_mask,
  input  logic [CHANNELS*WIDTH-1:0]   sig_in,
  change_event_logger_if.master       evt,
  output logic [$clog2(DEPTH):0]      level,
  output logic                        overflow,
  output logic [DROP_W-1:0]           drop_cnt
);
  typedef struct packed {
    logic [TS_WIDTH-1:0]       ts;
    logic [CHANNELS-1:0]       mask;
    logic [CHANNELS*WIDTH-1:0] data;
  } entry_t;

  logic [TS_WIDTH-1:0]       ts_cnt;
  logic [CHANNELS*WIDTH-1:0] prev;
  logic                      armed;
  logic [CHANNELS-1:0]       chg;
  logic                      push;
  logic                      pop;
  logic                      drop;
  logic                      full;
  logic                      empty;
  entry_t                    push_ent;
  entry_t                    head;

  always_comb begin
    chg = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      chg[i] = armed & en & ch_mask[i] &
               (sig_in[i*WIDTH +: WIDTH] != prev[i*WIDTH +: WIDTH]);
    end
  end

  always_comb begin
    push_ent      = '0;
    push_ent.ts   = ts_cnt;
    push_ent.mask = chg;
    push_ent.data = sig_in;
  end

  assign push = |chg;
  assign pop  = !empty && evt.out_ready;
  assign drop = push && full && !pop;

  event_fifo #(
    .DW    ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (push),
    .wr_dat (push_ent),
    .rd_en  (pop),
    .rd_dat (head),
    .full   (full),
    .empty  (empty),
    .level  (level)
  );

  // Head fields are forced to zero while empty so stale storage never shows.
  assign evt.out_valid = !empty;
  assign evt.evt_ts    = empty ? '0 : head.ts;
  assign evt.evt_mask  = empty ? '0 : head.mask;
  assign evt.evt_data  = empty ? '0 : head.data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_cnt   <= '0;
      prev     <= '0;
      armed    <= 1'b0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      prev  <= sig_in;
      armed <= 1'b1;
      if (en) ts_cnt <= ts_cnt + TS_WIDTH'(1);
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_change_event_logger.sv
// Randomised and directed bench for change_event_logger with a queue-based scoreboard.
module tb_change_event_logger;
  localparam int CH    = 3;
  localparam int W     = 1;
  localparam int DEPTH = 4;
  localparam int TSW   = 8;
  localparam int DRW   = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] ch_mask;
  logic [2:0] sig_in;
  logic [2:0] level;
  logic       overflow;
  logic [7:0] drop_cnt;

  change_event_logger_if #(.CHANNELS(CH), .WIDTH(W), .TS_WIDTH(TSW)) ifc ();

  change_event_logger #(
    .CHANNELS (CH),
    .WIDTH    (W),
    .DEPTH    (DEPTH),
    .TS_WIDTH (TSW),
    .DROP_W   (DRW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .ch_mask  (ch_mask),
    .sig_in   (sig_in),
    .evt      (ifc),
    .level    (level),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] ts;
    logic [2:0] mask;
    logic [2:0] data;
  } ent_t;

  int   checks   = 0;
  int   failures = 0;
  ent_t exp_q[$];
  ent_t mon_e;
  int   m_cnt;
  int   m_ts;
  int   m_drop;
  bit   m_ovf;
  bit   m_armed;
  logic [2:0] m_prev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the next edge does, given the inputs the DUT sees at that edge.
  task automatic model_edge();
    logic [2:0] chg;
    bit         pop;
    ent_t       e;
    if (rst) begin
      exp_q.delete();
      m_cnt = 0; m_ts = 0; m_drop = 0; m_ovf = 0; m_armed = 0; m_prev = '0;
      return;
    end
    chg = '0;
    for (int i = 0; i < CH; i++)
      if (m_armed && en && ch_mask[i] && (sig_in[i] != m_prev[i])) chg[i] = 1'b1;
    pop = ifc.out_ready && (m_cnt > 0);
    if (pop) m_cnt--;
    if (chg != 3'b000) begin
      if (m_cnt < DEPTH) begin
        e.ts = m_ts[7:0]; e.mask = chg; e.data = sig_in;
        exp_q.push_back(e);
        m_cnt++;
      end else begin
        m_ovf = 1;
        if (m_drop < 255) m_drop++;
      end
    end
    if (en) m_ts = (m_ts + 1) % 256;
    m_prev  = sig_in;
    m_armed = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Monitor: compares status every cycle and pops the scoreboard on each handshake.
  always @(negedge clk) begin
    if (!rst) begin
      chk("level", 32'(level), 32'(m_cnt));
      chk("out_valid", 32'(ifc.out_valid), 32'(m_cnt > 0));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (ifc.out_valid && ifc.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop_unexpected actual=ts%0h expected=no_entry", ifc.evt_ts);
        end else begin
          mon_e = exp_q.pop_front();
          chk("evt_ts", 32'(ifc.evt_ts), 32'(mon_e.ts));
          chk("evt_mask", 32'(ifc.evt_mask), 32'(mon_e.mask));
          chk("evt_data", 32'(ifc.evt_data), 32'(mon_e.data));
        end
      end else if (!ifc.out_valid) begin
        chk("empty_evt", {ifc.evt_ts, ifc.evt_mask, ifc.evt_data}, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; en = 1'b1; ch_mask = 3'b111; sig_in = 3'b010; ifc.out_ready = 1'b0;
    m_cnt = 0; m_ts = 0; m_drop = 0; m_ovf = 0; m_armed = 0; m_prev = '0;
    repeat (3) tick();
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_valid", 32'(ifc.out_valid), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    rst = 1'b0;

    // Arming edge must not report the 0 -> 010 difference.
    repeat (5) tick();
    chk("arm_valid", 32'(ifc.out_valid), 32'd0);
    chk("arm_level", 32'(level), 32'd0);

    repeat (5) tick();
    sig_in = 3'b011;
    tick();
    chk("t2_valid", 32'(ifc.out_valid), 32'd1);
    chk("t2_ts", 32'(ifc.evt_ts), 32'd10);
    chk("t2_mask", 32'(ifc.evt_mask), 32'b001);
    chk("t2_data", 32'(ifc.evt_data), 32'b011);
    ifc.out_ready = 1'b1; tick(); ifc.out_ready = 1'b0;

    ch_mask = 3'b110;
    sig_in = 3'b010;
    tick();
    chk("t3_masked_level", 32'(level), 32'd0);
    sig_in = 3'b111;
    tick();
    chk("t3_mask", 32'(ifc.evt_mask), 32'b100);
    chk("t3_data", 32'(ifc.evt_data), 32'b111);
    ifc.out_ready = 1'b1; tick(); ifc.out_ready = 1'b0;

    ch_mask = 3'b111;
    for (int i = 0; i < 6; i++) begin sig_in = sig_in ^ 3'b010; tick(); end
    chk("t4_level", 32'(level), 32'd4);
    chk("t4_drop", 32'(drop_cnt), 32'd2);
    chk("t4_ovf", 32'(overflow), 32'd1);
    ifc.out_ready = 1'b1; repeat (4) tick(); ifc.out_ready = 1'b0;
    chk("t4_drained", 32'(level), 32'd0);

    for (int i = 0; i < 4; i++) begin sig_in = sig_in ^ 3'b001; tick(); end
    ifc.out_ready = 1'b1;
    sig_in = sig_in ^ 3'b100;
    tick();
    chk("t5_level", 32'(level), 32'd4);
    chk("t5_drop", 32'(drop_cnt), 32'd2);
    repeat (4) tick();
    ifc.out_ready = 1'b0;

    n = 0;
    while (m_ts != 0 && n < 300) begin tick(); n++; end
    chk("t6_reach_wrap", 32'(m_ts), 32'd0);
    sig_in = sig_in ^ 3'b001;
    tick();
    chk("t6_ts_wrap", 32'(ifc.evt_ts), 32'd0);
    sig_in = sig_in ^ 3'b010;
    tick();
    ifc.out_ready = 1'b1;
    tick();
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(ifc.out_valid), 32'd0);
    chk("t6_rst_level", 32'(level), 32'd0);
    ifc.out_ready = 1'b0;
    tick();
    rst = 1'b0;

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) rst = 1'b1;
      en            = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) ch_mask = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) sig_in = 3'($urandom_range(0, 7));
      ifc.out_ready = ($urandom_range(0, 2) == 0);
      tick();
      rst = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
